mem_sram_ctrl: RTL and testbench
================================

# mem_sram_ctrl

- Memory-stage initiator that turns the pipeline's 32-bit load/store request into a two-phase 16-bit external SRAM access with fixed wait states.
- Holds a combinational `ready` low to freeze the pipeline while the access is in flight.
- Delivers the assembled 32-bit load word on `rd_data`, which feeds the `Mem_read_value_in` input of the MEM/WB pipeline register.
- Sits between the EXE/MEM register outputs and the board SRAM pins.

## Interface
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: cycles per 16-bit half access; legal values ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  1  load request (MEM_R_en from EXE/MEM).
- wr_en  in  1  store request (MEM_W_en from EXE/MEM).
- address  in  32  byte address (ALU result); bits [1:0] ignored.
- wr_data  in  32  store data (Val_Rm).
- rd_data  out  32  last completed load word.
- ready  out  1  0 = freeze pipeline; combinational from state and requests.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_oe  out  1  drive enable for the external tristate pad.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE. The wait counter is ceil(log2(WAIT_CYCLES)) bits.
- **IDLE**
  - ready = ~(rd_en | wr_en).
  - On a request, latch the op into the internal `is_wr` register (write wins if both are set), clear the counter, and go to LOW.
- **LOW / HIGH**
  - Each state lasts exactly WAIT_CYCLES cycles, counting 0..WAIT_CYCLES-1.
  - ready = 0.
  - LOW goes to HIGH, and HIGH goes to DONE, when count == WAIT_CYCLES-1.
- **DONE**
  - ready = 1 for exactly one cycle, then unconditionally IDLE.
  - The pipeline advances on this edge, so the request is never re-issued.
- Address mapping: word = (address − ADDR_BASE) >> 2, truncated to 17 bits; sram_addr = {word[16:0], half}, with half = 0 in LOW and 1 in HIGH.
- **Read**
  - sram_oe_n = 0 in LOW/HIGH; sram_we_n = 1; sram_dq_oe = 0.
  - On the last cycle of LOW, rd_data[15:0] ← sram_dq_in.
  - On the last cycle of HIGH, rd_data[31:16] ← sram_dq_in.
- **Write**
  - sram_dq_oe = 1 in LOW/HIGH.
  - sram_dq_out = wr_data[15:0] in LOW and wr_data[31:16] in HIGH.
  - sram_we_n = 0 for every cycle of each phase except its last (write closes before the address changes).
  - sram_oe_n = 1.
  - rd_data is unchanged.
- Outside LOW/HIGH: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
- rd_data holds its value until the next read overwrites it. The upper half is briefly stale between the two captures; this is never visible because ready = 0.

## Timing
- Reset values:
  - state IDLE, counter 0, rd_data 0.
  - sram_we_n 1, sram_oe_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0.
  - ready = 1 if no request is present.
- Latency from request in IDLE (cycle 0):
  - ready is 0 for cycles 0..2·WAIT_CYCLES.
  - ready is 1 in cycle 2·WAIT_CYCLES+1 (DONE). With the default WAIT_CYCLES = 3, that is 7 stall cycles and ready high at cycle 7.
  - rd_data is complete from cycle 2·WAIT_CYCLES+1 onward.
- Inputs must be held stable while ready = 0. The block samples address and wr_data combinationally each cycle and does not latch them.
- Back-to-back requests: DONE always inserts one IDLE cycle. A new request on the cycle after DONE starts at that IDLE and sees ready = 0.
- Reset mid-access:
  - Returns to IDLE on the next edge and de-asserts the strobes in that same edge.
  - rd_data is cleared to 0.
  - No partial-write retry.
- Address below ADDR_BASE: wraps modulo 2^17 words; no error flag.

## Test plan
- **No request:** rd_en = wr_en = 0 for 10 cycles → ready = 1 throughout; sram_we_n = sram_oe_n = 1; sram_dq_oe = 0.
- **Read:** read at address 0x408 with the model returning 0xBEEF at half-address 4 and 0xDEAD at half-address 5 → sram_addr = 4 for cycles 1–3 and 5 for cycles 4–6; ready = 0 for cycles 0–6; ready = 1 at cycle 7; rd_data = 0xDEADBEEF.
- **Write:** write 0x12345678 to 0x400 → LOW: sram_addr 0, sram_dq_out 0x5678, sram_we_n 0 for 2 cycles then 1. HIGH: sram_addr 1, sram_dq_out 0x1234, same strobe pattern. Readback of 0x400 returns 0x12345678.
- **Simultaneous requests:** rd_en = wr_en = 1 → write performed; sram_oe_n stays 1; rd_data unchanged.
- **Back-to-back reads:** two reads, to 0x400 then 0x404 → second access begins one cycle after DONE; ready is high for exactly one cycle between them; rd_data updates to each word in turn.
- **Reset mid-write:** rst asserted in the second LOW cycle of a write → next cycle: state IDLE, sram_we_n = 1, sram_dq_oe = 0, rd_data = 0; the following request completes normally.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// ============================================================================
// Module   : mem_sram_ctrl
// Purpose  : Memory-stage initiator. Splits a 32-bit load/store into two
//            16-bit SRAM phases with fixed wait states, stalling via ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_ctrl #(
   parameter int ADDR_BASE   = 1024,
   parameter int WAIT_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n,
   output logic        sram_oe_n
);

   localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          is_wr;
   logic          is_wr_nxt;
   logic          last;
   logic          active;
   logic          half;
   logic [31:0]   offset;
   logic [16:0]   word;
   logic          unused_addr_bits;

   // Word index relative to the SRAM window; wraps silently below the base.
   assign offset           = address - 32'(ADDR_BASE);
   assign word             = offset[18:2];
   assign unused_addr_bits = ^{offset[31:19], offset[1:0]};

   assign last   = (count == LAST);
   assign active = (state == LOW) || (state == HIGH);
   assign half   = (state == HIGH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         is_wr <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         is_wr <= is_wr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      is_wr_nxt = is_wr;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = ~(rd_en | wr_en);
            if (rd_en | wr_en) begin
               is_wr_nxt = wr_en;
               count_nxt = '0;
               state_nxt = LOW;
            end
         end
         LOW: begin
            if (last) begin
               count_nxt = '0;
               state_nxt = HIGH;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         HIGH: begin
            if (last) begin
               count_nxt = '0;
               state_nxt = DONE;
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         DONE: begin
            // Pipeline advances on this edge, so the request is not re-seen.
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write strobe drops on each phase's last cycle so data/address stay valid past WE rise.
   assign sram_addr   = active ? {word, half} : 18'd0;
   assign sram_dq_oe  = active & is_wr;
   assign sram_dq_out = (active & is_wr) ? (half ? wr_data[31:16] : wr_data[15:0]) : 16'd0;
   assign sram_we_n   = ~(active & is_wr & ~last);
   assign sram_oe_n   = ~(active & ~is_wr);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= 32'd0;
      end else if (!is_wr && last) begin
         if (state == LOW) begin
            rd_data[15:0] <= sram_dq_in;
         end else if (state == HIGH) begin
            rd_data[31:16] <= sram_dq_in;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
// ============================================================================
// Module   : tb_mem_sram_ctrl
// Purpose  : Self-checking bench for mem_sram_ctrl with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sram_ctrl;

   localparam int W = 3;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
   logic        sram_oe_n;

   int checks;
   int failures;

   logic [15:0] mem [0:255];

   mem_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n),
      .sram_oe_n   (sram_oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous-read SRAM, written on the rising edge while WE is low.
   assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];
   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
   end

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic check_idle_pins(input string tag);
      check({tag, " we_n"}, 32'(sram_we_n), 32'd1);
      check({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
      check({tag, " dq_oe"}, 32'(sram_dq_oe), 32'd0);
      check({tag, " addr"}, 32'(sram_addr), 32'd0);
      check({tag, " dq_out"}, 32'(sram_dq_out), 32'd0);
   endtask

   // Call just after a rising edge with the DUT in IDLE; returns one cycle after DONE.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input string tag);
      logic [16:0] word;
      bit          in_low, in_high, act, is_w;
      int          k;
      logic [17:0] e_addr;
      logic [15:0] e_dout;
      string       nm;
      word = 17'((addr - 32'd1024) >> 2);
      is_w = wr;
      rd_en = rd; wr_en = wr; address = addr; wr_data = wdata;
      for (int c = 0; c <= 2 * W + 1; c++) begin
         @(negedge clk);
         in_low  = (c >= 1) && (c <= W);
         in_high = (c > W) && (c <= 2 * W);
         act     = in_low || in_high;
         k       = in_low ? c - 1 : c - W - 1;
         e_addr  = act ? {word, in_high} : 18'd0;
         e_dout  = (act && is_w) ? (in_high ? wdata[31:16] : wdata[15:0]) : 16'd0;
         nm = $sformatf("%s c%0d", tag, c);
         check({nm, " ready"}, 32'(ready), 32'(c == 2 * W + 1));
         check({nm, " addr"}, 32'(sram_addr), 32'(e_addr));
         check({nm, " we_n"}, 32'(sram_we_n), 32'(!(act && is_w && k != W - 1)));
         check({nm, " oe_n"}, 32'(sram_oe_n), 32'(!(act && !is_w)));
         check({nm, " dq_oe"}, 32'(sram_dq_oe), 32'(act && is_w));
         check({nm, " dq_out"}, 32'(sram_dq_out), 32'(e_dout));
      end
      check({tag, " rd_data@done"}, rd_data, exp_rd);
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check({tag, " idle ready"}, 32'(ready), 32'd1);
      check({tag, " idle rd_data"}, rd_data, exp_rd);
      check_idle_pins({tag, " idle"});
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc;
      checks = 0; failures = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[4] = 16'hBEEF; mem[5] = 16'hDEAD;
      mem[2] = 16'h1111; mem[3] = 16'h2222;

      vecs[0] = '{rd: 1, wr: 0, addr: 32'h408, wdata: 32'h0,        exp_rd: 32'hDEADBEEF};
      vecs[1] = '{rd: 0, wr: 1, addr: 32'h400, wdata: 32'h12345678, exp_rd: 32'hDEADBEEF};
      vecs[2] = '{rd: 1, wr: 0, addr: 32'h400, wdata: 32'h0,        exp_rd: 32'h12345678};
      vecs[3] = '{rd: 1, wr: 1, addr: 32'h40C, wdata: 32'hCAFEF00D, exp_rd: 32'h12345678};
      vecs[4] = '{rd: 1, wr: 0, addr: 32'h40C, wdata: 32'h0,        exp_rd: 32'hCAFEF00D};
      vecs[5] = '{rd: 0, wr: 1, addr: 32'h3FC, wdata: 32'hA5A55A5A, exp_rd: 32'hCAFEF00D};
      vecs[6] = '{rd: 1, wr: 0, addr: 32'h3FC, wdata: 32'h0,        exp_rd: 32'hA5A55A5A};
      vecs[7] = '{rd: 1, wr: 0, addr: 32'h40A, wdata: 32'h0,        exp_rd: 32'hDEADBEEF};

      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; wr_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset ready", 32'(ready), 32'd1);
      check("reset rd_data", rd_data, 32'd0);
      check_idle_pins("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // No request for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("noreq c%0d ready", i), 32'(ready), 32'd1);
         check_idle_pins($sformatf("noreq c%0d", i));
      end
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                   $sformatf("vec%0d", i));
      end

      // Back-to-back reads with the request held across DONE.
      rd_en = 1'b1; address = 32'h400;
      cyc = 0;
      @(negedge clk);
      while (!ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b first latency", 32'(cyc), 32'(2 * W + 1));
      check("b2b first rd_data", rd_data, 32'h12345678);
      @(posedge clk); #1;
      address = 32'h404;
      @(negedge clk);
      check("b2b gap ready", 32'(ready), 32'd0);
      check("b2b gap addr", 32'(sram_addr), 32'd0);
      cyc = 0;
      while (!ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b second latency", 32'(cyc), 32'(2 * W + 1));
      check("b2b second rd_data", rd_data, 32'h22221111);
      @(posedge clk); #1;
      rd_en = 1'b0;
      @(negedge clk);
      check("b2b after ready", 32'(ready), 32'd1);
      @(posedge clk); #1;

      // Reset during the second LOW cycle of a write.
      wr_en = 1'b1; address = 32'h410; wr_data = 32'h55556666;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid pre we_n", 32'(sram_we_n), 32'd0);
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid ready", 32'(ready), 32'd1);
      check("rstmid rd_data", rd_data, 32'd0);
      check_idle_pins("rstmid");
      @(posedge clk); #1;
      do_access(1'b1, 1'b0, 32'h408, 32'h0, 32'hDEADBEEF, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
